// File: rtl/bcd_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_scanner
// Brief    : Time-multiplexed BCD digit scanner with frame-synchronous,
//            double-buffered loads. Option macro: BCD_SCAN_LEADING_ZERO_BLANK_EN
// Revision : 1.0
// ============================================================================
module bcd_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [DIV_WIDTH-1:0]    div_tc,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    bcd_valid,
  output logic                    frame_done,
  output logic                    err_sticky
);

  localparam int c_IDX_W  = $clog2(NUM_DIGITS);
  localparam int c_BLK_W  = $clog2(BLANK_CYCLES) + 1;
  localparam int c_CNT_W  = (DIV_WIDTH > c_BLK_W) ? DIV_WIDTH : c_BLK_W;
  localparam int c_DATA_W = 4 * NUM_DIGITS;
  localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                r_state, w_state_nx;
  logic [c_CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [c_CNT_W-1:0]    r_tc, w_tc_nx;
  logic [c_IDX_W-1:0]    r_idx, w_idx_nx;
  logic [c_DATA_W-1:0]   r_active, w_active_nx;
  logic [c_DATA_W-1:0]   r_shadow, w_shadow_nx;
  logic                  r_pending, w_pending_nx;
  logic                  r_err_sticky, w_err_nx;

  logic [NUM_DIGITS-1:0] r_digit_en;
  logic [3:0]            r_bcd_out;
  logic                  r_bcd_valid;
  logic                  r_frame_done;
  logic                  r_load_ready;

  logic                  w_show_end;
  logic                  w_commit;
  logic                  w_shown;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [c_DATA_W-1:0]   w_sanitised;
  logic [NUM_DIGITS-1:0] w_bad;

  // Codes 10..15 never reach the decoders; they become 0 on commit.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_sanitise
    assign w_bad[g]              = (r_shadow[4*g +: 4] > 4'd9);
    assign w_sanitised[4*g +: 4] = w_bad[g] ? 4'd0 : r_shadow[4*g +: 4];
  end

  assign w_show_end = (r_state == ST_SHOW) && (r_cnt == r_tc);
  assign w_commit   = w_show_end && (r_idx == c_IDX_LAST) && r_pending;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt + 1'b1;
    w_tc_nx      = r_tc;
    w_idx_nx     = r_idx;
    w_active_nx  = r_active;
    w_shadow_nx  = r_shadow;
    w_pending_nx = r_pending;
    w_err_nx     = r_err_sticky;

    case (r_state)
      ST_BLANK: begin
        if (r_cnt == c_BLANK_LAST) begin
          w_state_nx = ST_SHOW;
          w_cnt_nx   = '0;
          w_tc_nx    = c_CNT_W'(div_tc);
        end
      end
      ST_SHOW: begin
        if (w_show_end) begin
          w_state_nx = ST_BLANK;
          w_cnt_nx   = '0;
          w_idx_nx   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_BLANK;
        w_cnt_nx   = '0;
      end
    endcase

    // Commit and transfer are exclusive: a transfer needs pending low.
    if (w_commit) begin
      w_active_nx  = w_sanitised;
      w_pending_nx = 1'b0;
      w_err_nx     = r_err_sticky | (|w_bad);
    end else if (load_valid && !r_pending) begin
      w_shadow_nx  = load_data;
      w_pending_nx = 1'b1;
    end
  end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_zero_from;

  // w_zero_from[i]: digits i..NUM_DIGITS-1 of the next active value are all 0.
  always_comb begin
    logic w_all_zero;
    w_zero_from = '0;
    w_all_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_all_zero     = w_all_zero & (w_active_nx[4*i +: 4] == 4'd0);
      w_zero_from[i] = w_all_zero;
    end
  end

  assign w_shown = (w_idx_nx == '0) || !w_zero_from[w_idx_nx];
`else
  assign w_shown = 1'b1;
`endif

  assign w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx_nx;
  assign w_lit    = (w_state_nx == ST_SHOW) && w_shown;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_tc         <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_digit_en   <= '0;
      r_bcd_out    <= 4'd0;
      r_bcd_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_tc         <= w_tc_nx;
      r_idx        <= w_idx_nx;
      r_active     <= w_active_nx;
      r_shadow     <= w_shadow_nx;
      r_pending    <= w_pending_nx;
      r_err_sticky <= w_err_nx;
      // Outputs are registered from next-state values so they line up with
      // the state they describe; bcd_out leads the strobe through BLANK.
      r_digit_en   <= w_lit ? w_onehot : '0;
      r_bcd_out    <= w_active_nx[{w_idx_nx, 2'b00} +: 4];
      r_bcd_valid  <= w_lit;
      r_frame_done <= (w_state_nx == ST_SHOW) && (w_idx_nx == c_IDX_LAST) &&
                      (w_cnt_nx == w_tc_nx);
      r_load_ready <= !w_pending_nx;
    end
  end

  assign digit_en   = r_digit_en;
  assign bcd_out    = r_bcd_out;
  assign bcd_valid  = r_bcd_valid;
  assign frame_done = r_frame_done;
  assign load_ready = r_load_ready;
  assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_digit_scanner
// Brief    : Directed and randomized bench for bcd_digit_scanner against a
//            slot-position reference model.
// Revision : 1.0
// ============================================================================
module tb_bcd_digit_scanner;

  localparam int NUM_DIGITS   = 4;
  localparam int DIV_WIDTH    = 16;
  localparam int BLANK_CYCLES = 2;
  localparam int LD_W         = 4 * NUM_DIGITS;

  logic                  clk;
  logic                  rst_n;
  logic                  load_valid;
  logic                  load_ready;
  logic [LD_W-1:0]       load_data;
  logic [DIV_WIDTH-1:0]  div_tc;
  logic [3:0]            bcd_out;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  bcd_valid;
  logic                  frame_done;
  logic                  err_sticky;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position inside the current digit slot (BLANK then SHOW)
  int              m_pos;
  int              m_idx;
  int              m_tc;
  int              m_active [NUM_DIGITS];
  logic [LD_W-1:0] m_shadow;
  bit              m_pending;
  bit              m_err;

  bcd_digit_scanner #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DIV_WIDTH   (DIV_WIDTH),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .div_tc    (div_tc),
    .bcd_out   (bcd_out),
    .digit_en  (digit_en),
    .bcd_valid (bcd_valid),
    .frame_done(frame_done),
    .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos     = 0;
    m_idx     = 0;
    m_tc      = 0;
    m_shadow  = '0;
    m_pending = 0;
    m_err     = 0;
    for (int i = 0; i < NUM_DIGITS; i++) m_active[i] = 0;
  endtask

  function automatic bit m_shown(input int i);
    if (i == 0) return 1'b1;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    for (int j = i; j < NUM_DIGITS; j++) if (m_active[j] != 0) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    bit show;
    bit last;
    int d;
    show = (m_pos >= BLANK_CYCLES);
    last = show && (m_pos == BLANK_CYCLES + m_tc);
    if (last && (m_idx == NUM_DIGITS - 1) && m_pending) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        d = int'(m_shadow[4*i +: 4]);
        if (d > 9) begin
          m_active[i] = 0;
          m_err       = 1'b1;
        end else begin
          m_active[i] = d;
        end
      end
      m_pending = 1'b0;
    end else if (load_valid && !m_pending) begin
      m_shadow  = load_data;
      m_pending = 1'b1;
    end
    if (last) begin
      m_pos = 0;
      m_idx = (m_idx + 1) % NUM_DIGITS;
    end else begin
      m_pos++;
      if (m_pos == BLANK_CYCLES) m_tc = int'(div_tc);
    end
  endtask

  task automatic check_outputs();
    bit                    show;
    bit                    lit;
    logic [NUM_DIGITS-1:0] exp_en;
    show   = (m_pos >= BLANK_CYCLES);
    lit    = show && m_shown(m_idx);
    exp_en = '0;
    if (lit) exp_en[m_idx] = 1'b1;
    check("digit_en",   32'(digit_en),   32'(exp_en));
    check("bcd_out",    32'(bcd_out),    32'(m_active[m_idx]));
    check("bcd_valid",  32'(bcd_valid),  32'(lit));
    check("frame_done", 32'(frame_done),
          32'(show && (m_idx == NUM_DIGITS - 1) && (m_pos == BLANK_CYCLES + m_tc)));
    check("load_ready", 32'(load_ready), 32'(!m_pending));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s observed=timeout expected=condition reached", tag);
  endtask

  function automatic logic [LD_W-1:0] rand_digits();
    logic [LD_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      v[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    bit found;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    div_tc     = DIV_WIDTH'(3);
    model_reset();

    // Reset state, then release and watch the first frames of zeros.
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    run(30);

    // Load 1234 mid-frame.
    run(5);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    tick();
    load_valid = 1'b0;
    load_data  = LD_W'($urandom);
    run(50);

    // Hold load_valid with 5678 while a load is pending.
    load_valid = 1'b1;
    load_data  = 16'h1111;
    tick();
    load_data  = 16'h5678;
    run(60);
    load_valid = 1'b0;
    run(60);

    // Invalid digit 0xA is sanitised and sets err_sticky.
    load_valid = 1'b1;
    load_data  = 16'h00A1;
    tick();
    load_valid = 1'b0;
    run(60);

    // Minimum dwell, then a div_tc change in the middle of a dwell.
    div_tc = DIV_WIDTH'(0);
    run(30);
    div_tc = DIV_WIDTH'(2);
    found  = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      found = (m_pos == BLANK_CYCLES + 1) && (m_tc == 2);
    end
    if (!found) timeout("mid_show_wait");
    div_tc = DIV_WIDTH'(5);
    run(40);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = rand_digits();
      if ($urandom_range(0, 19) == 0) div_tc = DIV_WIDTH'($urandom_range(0, 4));
      tick();
    end
    load_valid = 1'b0;

    // Asynchronous reset mid-SHOW with a load pending.
    div_tc     = DIV_WIDTH'(3);
    load_valid = 1'b1;
    load_data  = 16'h4321;
    tick();
    load_valid = 1'b0;
    found      = m_pending && (m_pos > BLANK_CYCLES);
    for (int k = 0; k < 100 && !found; k++) begin
      if (!m_pending) load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      found = m_pending && (m_pos > BLANK_CYCLES);
    end
    if (!found) timeout("pending_show_wait");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    run(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
